sound_irq_gen: RTL and testbench

SOUND_IRQ_GEN -- requirements
Module: sound_irq_gen

---
 rtl/sound_irq_gen.sv | 98 +++++++++
 tb/tb_sound_irq_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_irq_gen.sv
// Sound-latch write to Z80 /INT generator: edge-detects snd_wr on cen_3m, asserts /INT on the next n_cen_3m tick.
// Latency one n_cen_3m tick after the sampling cen_3m tick; extra writes while busy are counted, never queued.
module sound_irq_gen #(
  parameter int TMO_CYCLES = 49152,
  parameter int OVR_W      = 4
) (
  input  logic             clk_49m,
  input  logic             sirq_clr,
  input  logic             cen_3m,
  input  logic             n_cen_3m,
  input  logic             snd_wr,
  output logic             z80_n_int,
  output logic             irq_active,
  output logic [1:0]       state,
  output logic             tmo_flag,
  output logic [OVR_W-1:0] ovr_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARMED  = 2'b01;
  localparam logic [1:0] ST_ASSERT = 2'b10;

  localparam logic        TMO_EN   = (TMO_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TMO_EN ? TMO_CYCLES - 1 : 0);

  logic        snd_prev;
  logic [15:0] tmo_cnt;
  logic        req;
  logic        tmo_hit;
  logic        busy;
  logic        ovr_sat;

  assign req     = cen_3m & snd_wr & ~snd_prev;
  assign tmo_hit = n_cen_3m & TMO_EN & (tmo_cnt == TMO_LAST);
  assign busy    = (state != ST_IDLE);
  assign ovr_sat = &ovr_cnt;

  // snd_prev resets high so a write still held across a clear cannot retrigger.
  always_ff @(posedge clk_49m or posedge sirq_clr) begin
    if (sirq_clr) begin
      snd_prev <= 1'b1;
    end else if (cen_3m) begin
      snd_prev <= snd_wr;
    end
  end

  always_ff @(posedge clk_49m or posedge sirq_clr) begin
    if (sirq_clr) begin
      state      <= ST_IDLE;
      z80_n_int  <= 1'b1;
      irq_active <= 1'b0;
      tmo_flag   <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state   <= ST_ARMED;
            tmo_cnt <= '0;
          end
        end
        ST_ARMED: begin
          if (n_cen_3m) begin
            state      <= ST_ASSERT;
            z80_n_int  <= 1'b0;
            irq_active <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Only a timeout leaves ASSERT here; acknowledge arrives as sirq_clr.
          if (tmo_hit) begin
            state      <= ST_IDLE;
            z80_n_int  <= 1'b1;
            irq_active <= 1'b0;
            tmo_flag   <= 1'b1;
          end else if (n_cen_3m) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          z80_n_int  <= 1'b1;
          irq_active <= 1'b0;
        end
      endcase
    end
  end

  // A request coinciding with a timeout exit still sees busy=1, so it counts as overrun.
  always_ff @(posedge clk_49m or posedge sirq_clr) begin
    if (sirq_clr) begin
      ovr_cnt <= '0;
    end else if (req && busy && !ovr_sat) begin
      ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end

endmodule

// File: tb/tb_sound_irq_gen.sv
// Scoreboarded bench for sound_irq_gen: directed scenarios followed by random enables, writes and clears.
module tb_sound_irq_gen;

  localparam int TMO     = 4;
  localparam int OVW     = 2;
  localparam int OVR_MAX = (1 << OVW) - 1;

  logic           clk_49m  = 1'b0;
  logic           sirq_clr = 1'b1;
  logic           cen_3m   = 1'b0;
  logic           n_cen_3m = 1'b0;
  logic           snd_wr   = 1'b0;
  logic           z80_n_int;
  logic           irq_active;
  logic [1:0]     state;
  logic           tmo_flag;
  logic [OVW-1:0] ovr_cnt;

  always #5 clk_49m = ~clk_49m;

  sound_irq_gen #(.TMO_CYCLES(TMO), .OVR_W(OVW)) dut (
    .clk_49m    (clk_49m),
    .sirq_clr   (sirq_clr),
    .cen_3m     (cen_3m),
    .n_cen_3m   (n_cen_3m),
    .snd_wr     (snd_wr),
    .z80_n_int  (z80_n_int),
    .irq_active (irq_active),
    .state      (state),
    .tmo_flag   (tmo_flag),
    .ovr_cnt    (ovr_cnt)
  );

  typedef struct packed {
    logic [1:0]     st;
    logic           nint;
    logic           act;
    logic           flag;
    logic [OVW-1:0] ovr;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: phase 0 idle, 1 waiting for the Z80 tick, 2 interrupt low.
  bit m_prev  = 1'b1;
  int m_phase = 0;
  int m_low   = 0;
  bit m_flag  = 1'b0;
  int m_ovr   = 0;

  function automatic void model_reset();
    m_prev  = 1'b1;
    m_phase = 0;
    m_low   = 0;
    m_flag  = 1'b0;
    m_ovr   = 0;
  endfunction

  function automatic void model_step(input bit cen, input bit ncen, input bit wr);
    bit req;
    bit busy;
    req  = cen && wr && !m_prev;
    busy = (m_phase != 0);
    if (cen) m_prev = wr;
    if (req && busy && m_ovr < OVR_MAX) m_ovr = m_ovr + 1;
    case (m_phase)
      0: if (req) m_phase = 1;
      1: if (ncen) begin m_phase = 2; m_low = 0; end
      default: begin
        if (ncen) begin
          m_low = m_low + 1;
          // Interrupt has now been low for m_low Z80 ticks.
          if (m_low >= TMO) begin
            m_phase = 0;
            m_flag  = 1'b1;
          end
        end
      end
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st   = 2'(m_phase);
    o.nint = (m_phase != 2);
    o.act  = (m_phase == 2);
    o.flag = m_flag;
    o.ovr  = OVW'(m_ovr);
    return o;
  endfunction

  // One clock: account for the edge just taken, apply new inputs, queue the expected outputs.
  task automatic cycle(input bit cen, input bit ncen, input bit wr, input bit clr);
    @(posedge clk_49m);
    #1;
    if (!sirq_clr) model_step(cen_3m, n_cen_3m, snd_wr);
    cen_3m   = cen;
    n_cen_3m = ncen;
    snd_wr   = wr;
    sirq_clr = clr;
    if (clr) model_reset();
    exp_q.push_back(model_obs());
    cyc++;
  endtask

  task automatic run(input int n, input bit wr, input bit ncen_on);
    for (int i = 0; i < n; i++)
      cycle((i % 4) == 0, ncen_on && ((i % 4) == 2), wr, 1'b0);
  endtask

  task automatic expect_now(input string name, input logic [1:0] st, input logic nint,
                            input logic flag, input logic [OVW-1:0] ovr);
    #1;
    checks++;
    if (state !== st || z80_n_int !== nint || irq_active !== !nint ||
        tmo_flag !== flag || ovr_cnt !== ovr) begin
      errors++;
      $display("FAIL %s: got state=%b n_int=%b act=%b flag=%b ovr=%0d, expected state=%b n_int=%b act=%b flag=%b ovr=%0d",
               name, state, z80_n_int, irq_active, tmo_flag, ovr_cnt, st, nint, !nint, flag, ovr);
    end
  endtask

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk_49m);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, z80_n_int, irq_active, tmo_flag, ovr_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got st/nint/act/flag/ovr=%b expected %b", cyc, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    expect_now("reset", 2'b00, 1'b1, 1'b0, 2'd0);

    // Single write held for two cen ticks.
    run(4, 1'b0, 1'b1);
    run(8, 1'b1, 1'b1);
    expect_now("single_write", 2'b10, 1'b0, 1'b0, 2'd0);

    // Acknowledge is asynchronous.
    cycle(0, 0, 0, 1);
    expect_now("ack_async", 2'b00, 1'b1, 1'b0, 2'd0);

    // Overrun with no Z80 ticks so ASSERT cannot time out.
    run(4, 1'b0, 1'b1);
    run(4, 1'b1, 1'b0);
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      run(4, 1'b0, 1'b0);
      run(4, 1'b1, 1'b0);
    end
    expect_now("overrun3", 2'b10, 1'b0, 1'b0, 2'd3);
    for (int k = 0; k < 2; k++) begin
      run(4, 1'b0, 1'b0);
      run(4, 1'b1, 1'b0);
    end
    expect_now("overrun_sat", 2'b10, 1'b0, 1'b0, 2'd3);
    cycle(0, 0, 0, 1);

    // Timeout after exactly TMO Z80 ticks low.
    run(4, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    run(12, 1'b0, 1'b1);
    expect_now("tmo_before", 2'b10, 1'b0, 1'b0, 2'd0);
    run(4, 1'b0, 1'b1);
    expect_now("timeout", 2'b00, 1'b1, 1'b1, 2'd0);
    run(4, 1'b1, 1'b1);
    expect_now("rearm", 2'b10, 1'b0, 1'b1, 2'd0);
    cycle(0, 0, 0, 1);
    expect_now("flag_clear", 2'b00, 1'b1, 1'b0, 2'd0);

    // Clear while the write is still held high.
    run(4, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    cycle(0, 0, 1, 1);
    run(12, 1'b1, 1'b1);
    expect_now("held_write", 2'b00, 1'b1, 1'b0, 2'd0);
    run(4, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    expect_now("after_held", 2'b10, 1'b0, 1'b0, 2'd0);
    cycle(0, 0, 0, 1);

    // Coincident enables on the sampling cycle.
    run(4, 1'b0, 1'b1);
    cycle(1, 1, 1, 0);
    cycle(0, 0, 1, 0);
    expect_now("coincident", 2'b01, 1'b1, 1'b0, 2'd0);
    cycle(0, 0, 1, 0);
    expect_now("coincident_hold", 2'b01, 1'b1, 1'b0, 2'd0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    expect_now("coincident_assert", 2'b10, 1'b0, 1'b0, 2'd0);
    cycle(0, 0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      bit wr;
      wr = (($urandom % 6) == 0) ? !snd_wr : snd_wr;
      cycle(($urandom % 3) == 0, ($urandom % 3) == 0, wr, ($urandom % 150) == 0);
    end

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
